// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; both
// run on magnitudes for WIDTH cycles and fix up signs in one extra cycle.
// Handshake: an op on op_valid is accepted only in a non-busy cycle; while
// busy, op_valid/rd_hi/rd_lo are ignored for state and only raise
// mult_div_stall, and upstream holds the request until busy falls.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             mult_div_stall,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        count_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {running remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc_q;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     dividend_q;
  logic                 is_div_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 dbz_q;

  // Acceptance-time operand conditioning
  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // Per-cycle datapath and fix-up results
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]       div_trial;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_acc;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 div_zero;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  // Latch magnitudes for signed ops; unsigned ops pass operands through
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op && rs_val[WIDTH-1];
    b_neg     = signed_op && rt_val[WIDTH-1];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag     = b_neg ? -rt_val : rt_val;
  end

  // One shift-add or restoring-division step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};

    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opnd_q});
    // When div_ge holds the difference is below opnd_q, so WIDTH bits suffice
    div_sub   = div_trial[WIDTH-1:0] - opnd_q;
    div_rem   = div_ge ? div_sub : div_trial[WIDTH-1:0];
    div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

    acc_d     = is_div_q ? div_acc : mul_acc;
  end

  // Sign fix-up and final HI/LO selection, including divide-by-zero override
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero = (opnd_q == '0);
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero) begin
        hi_d = dividend_q;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quot_fix;
      end
    end
  end

  // Control FSM with registered busy / div_by_zero and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc_q    <= {{WIDTH{1'b0}}, b_mag};
                opnd_q   <= a_mag;
                is_div_q <= 1'b0;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= a_neg;
                count_q  <= '0;
                busy_q   <= 1'b1;
                state_q  <= ST_CALC;
              end
              OP_DIV, OP_DIVU: begin
                acc_q      <= {{WIDTH{1'b0}}, a_mag};
                opnd_q     <= b_mag;
                dividend_q <= rs_val;
                is_div_q   <= 1'b1;
                neg_lo_q   <= a_neg ^ b_neg;
                neg_hi_q   <= a_neg;
                count_q    <= '0;
                busy_q     <= 1'b1;
                state_q    <= ST_CALC;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_q <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= is_div_q && div_zero;
          count_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi             = hi_q;
  assign lo             = lo_q;
  assign busy           = busy_q;
  assign div_by_zero    = dbz_q;
  assign mult_div_stall = busy_q && (op_valid || rd_hi || rd_lo);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mult_div_stall;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_valid       (op_valid),
    .op             (op),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .rd_hi          (rd_hi),
    .rd_lo          (rd_lo),
    .hi             (hi),
    .lo             (lo),
    .busy           (busy),
    .mult_div_stall (mult_div_stall),
    .div_by_zero    (div_by_zero),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present an op in the current cycle, then follow busy until it falls.
  // Returns the busy cycle count and how many busy cycles had div_by_zero high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n, output int dz);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    n = 0; dz = 0;
    while (busy && n < 60) begin
      n++;
      if (div_by_zero) dz++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd7; rs_val = '0; rt_val = '0;
    rd_hi = 1'b1; rd_lo = 1'b0;
    #12;
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (mult_div_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", mult_div_stall); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rd_hi = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_signed();
    int n, dz;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, n, dz);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL mult_latency got %0d exp 33", n); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h exp %h", hi, 32'hFFFF_FFFF); end
    vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_lo got %h exp %h", lo, 32'hFFFF_FFEB); end
    vectors++; if (dz !== 0 || div_by_zero !== 1'b0) begin miscompares++; $display("FAIL mult_dbz got %0d/%b exp 0/0", dz, div_by_zero); end
  endtask

  task automatic test_multu();
    int n, dz;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, dz);
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h exp %h", hi, 32'hFFFF_FFFE); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h exp %h", lo, 32'h1); end
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, dz);
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL mult_m1_hi got %h exp %h", hi, 32'h0); end
    vectors++; if (lo !== 32'h1) begin miscompares++; $display("FAIL mult_m1_lo got %h exp %h", lo, 32'h1); end
  endtask

  task automatic test_div_signed();
    int n, dz;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n, dz);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL div_latency got %0d exp 33", n); end
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo got %h exp %h", lo, 32'hFFFF_FFFD); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi got %h exp %h", hi, 32'hFFFF_FFFF); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n, dz);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_lo got %h exp %h", lo, 32'h8000_0000); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi got %h exp %h", hi, 32'h0); end
    run_op(3'd3, 32'd100, 32'd7, n, dz);
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL divu_100_7 got %h/%h exp %h/%h", hi, lo, 32'd2, 32'd14); end
  endtask

  task automatic test_div_by_zero();
    int n, dz;
    run_op(3'd3, 32'd5, 32'd0, n, dz);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL dbz_latency got %0d exp 33", n); end
    vectors++; if (dz !== 0) begin miscompares++; $display("FAIL dbz_early got %0d exp 0", dz); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_pulse got %b exp 1", div_by_zero); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dbz_lo got %h exp %h", lo, 32'hFFFF_FFFF); end
    vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL dbz_hi got %h exp %h", hi, 32'd5); end
    @(posedge clk); #1;
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_width got %b exp 0", div_by_zero); end
    run_op(3'd2, 32'hFFFF_FFF8, 32'd0, n, dz);
    vectors++; if (hi !== 32'hFFFF_FFF8 || lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dbz_signed got %h/%h exp %h/%h", hi, lo, 32'hFFFF_FFF8, 32'hFFFF_FFFF); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_signed_pulse got %b exp 1", div_by_zero); end
  endtask

  task automatic test_stall();
    int n, bad;
    // MFHI held from T+1 while a MULT runs
    op_valid = 1'b1; op = 3'd0; rs_val = 32'h1234_5678; rt_val = 32'h10;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7; rd_hi = 1'b1;
    n = 0; bad = 0;
    while (busy && n < 60) begin
      n++;
      if (mult_div_stall !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL stall_latency got %0d exp 33", n); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_busy got %0d low cycles exp 0", bad); end
    vectors++; if (mult_div_stall !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b exp 0", mult_div_stall); end
    vectors++; if (hi !== 32'h1) begin miscompares++; $display("FAIL stall_hi got %h exp %h", hi, 32'h1); end
    vectors++; if (lo !== 32'h2345_6780) begin miscompares++; $display("FAIL stall_lo got %h exp %h", lo, 32'h2345_6780); end
    rd_hi = 1'b0;
    // MTLO held during busy must wait for busy to fall
    op_valid = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk); #1;
    op = 3'd5; rs_val = 32'hCAFE_F00D; rt_val = 32'd0;
    n = 0; bad = 0;
    while (busy && n < 60) begin
      n++;
      if (lo !== 32'h2345_6780 || mult_div_stall !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    vectors++; if (n !== 33 || bad !== 0) begin miscompares++; $display("FAIL mtlo_hold got %0d/%0d exp 33/0", n, bad); end
    vectors++; if (lo !== 32'd6 || hi !== 32'd0) begin miscompares++; $display("FAIL mtlo_mult got %h/%h exp %h/%h", hi, lo, 32'd0, 32'd6); end
    vectors++; if (mult_div_stall !== 1'b0) begin miscompares++; $display("FAIL mtlo_stall got %b exp 0", mult_div_stall); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    vectors++; if (lo !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL mtlo_write got %h exp %h", lo, 32'hCAFE_F00D); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    // MTHI then a no-op code
    op_valid = 1'b1; op = 3'd4; rs_val = 32'h0BAD_BEEF;
    @(posedge clk); #1;
    op = 3'd6; rs_val = 32'h1111_1111; rt_val = 32'h2222_2222;
    vectors++; if (hi !== 32'h0BAD_BEEF || busy !== 1'b0) begin miscompares++; $display("FAIL mthi got %h/%b exp %h/0", hi, busy, 32'h0BAD_BEEF); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    vectors++; if (hi !== 32'h0BAD_BEEF || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin miscompares++; $display("FAIL noop got %h/%h/%b exp %h/%h/0", hi, lo, busy, 32'h0BAD_BEEF, 32'hCAFE_F00D); end
  endtask

  task automatic test_back_to_back();
    int n, dz;
    run_op(3'd1, 32'd3, 32'd5, n, dz);
    vectors++; if (lo !== 32'd15 || hi !== 32'd0) begin miscompares++; $display("FAIL b2b_first got %h/%h exp %h/%h", hi, lo, 32'd0, 32'd15); end
    run_op(3'd3, 32'd100, 32'd7, n, dz);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL b2b_latency got %0d exp 33", n); end
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL b2b_second got %h/%h exp %h/%h", hi, lo, 32'd2, 32'd14); end
  endtask

  task automatic test_reset_mid();
    int n, dz;
    op_valid = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7; rd_hi = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    vectors++; if (busy !== 1'b1 || mult_div_stall !== 1'b1) begin miscompares++; $display("FAIL mid_before got %b/%b exp 1/1", busy, mult_div_stall); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b exp 0", busy); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL mid_hilo got %h/%h exp 0/0", hi, lo); end
    vectors++; if (mult_div_stall !== 1'b0) begin miscompares++; $display("FAIL mid_stall got %b exp 0", mult_div_stall); end
    rd_hi = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd1, 32'd3, 32'd4, n, dz);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL post_reset_latency got %0d exp 33", n); end
    vectors++; if (lo !== 32'd12 || hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_result got %h/%h exp %h/%h", hi, lo, 32'd0, 32'd12); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_div_signed();
    test_div_by_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS core's execute stage. It owns the HI/LO registers and runs MULT, MULTU, DIV and DIVU over multiple cycles. It serves MTHI/MTLO writes and MFHI/MFLO read requests. Its `mult_div_stall` output feeds the stall unit directly, which freezes decode, execute and the register file while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  execute stage presents a HI/LO-writing instruction this cycle.
- `op`  in  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are no-ops.
- `rs_val`  in  WIDTH  operand A (dividend, multiplicand, or MTHI/MTLO data).
- `rt_val`  in  WIDTH  operand B (divisor or multiplier).
- `rd_hi`  in  1  MFHI request this cycle.
- `rd_lo`  in  1  MFLO request this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress (registered).
- `mult_div_stall`  out  1  to stall unit. Combinational: `busy && (op_valid || rd_hi || rd_lo)`.
- `div_by_zero`  out  1  one-cycle pulse when a DIV/DIVU with `rt_val == 0` completes.

## Operation
- States: IDLE, CALC, FIXUP.
- **Accept:** In IDLE, with `op_valid` and op 0–3, the unit latches operands and the operation, then enters CALC with `count = 0`.
  - Signed ops (MULT, DIV) latch absolute values and record the result signs.
  - Product sign is `a_sign ^ b_sign`. Quotient sign is the same. Remainder sign is `a_sign`.
- **CALC, multiply:** One radix-2 shift-add step per cycle on a 2·WIDTH accumulator.
- **CALC, divide:** One restoring-division step per cycle, producing 1 quotient bit and a running remainder.
- **CALC exit:** After `count == WIDTH-1`, the unit moves to FIXUP.
- **FIXUP:** Applies two's-complement negation where the recorded sign requires it, then writes HI/LO and returns to IDLE.
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero:** LO = all ones, HI = the original (signed) dividend, and `div_by_zero` pulses during the FIXUP→IDLE cycle. The unit still takes the full latency.
- **Signed overflow** (−2^WIDTH−1 ÷ −1): LO = 0x80000000, HI = 0. The magnitude path truncates naturally to these values.
- **MTHI/MTLO:** In IDLE, the unit writes `rs_val` to HI or LO at the clock edge. These take a single cycle and never assert `busy`.
- **While busy:** `op_valid` and `rd_*` are ignored for state purposes and only raise `mult_div_stall`. Upstream holds the instruction and re-presents it once `busy` falls.
- **MFHI/MFLO:** `rd_hi`/`rd_lo` never change state. A request in a non-busy cycle reads the current `hi`/`lo`.

## Timing
- **Reset** (async, any state including mid-CALC): state IDLE, `count` 0, `hi` 0, `lo` 0, `busy` 0, `div_by_zero` 0. Any in-flight result is discarded.
- **Acceptance and latency:** An operation accepted at the edge ending cycle T gives:
  - `busy` = 1 in cycles T+1 … T+WIDTH+1 (33 cycles for WIDTH = 32).
  - New `hi`/`lo` values visible in cycle T+WIDTH+2, which is also when `busy` = 0.
- **Back-to-back:** A new `op_valid` presented in the first non-busy cycle is accepted that cycle, so there is no dead cycle between operations.
- **Stall response:** `mult_div_stall` responds in the same cycle as its inputs, with no register delay. It is low in the cycle `busy` falls, so a waiting MFHI/MFLO reads the final value in that cycle.
- **MTHI/MTLO** presented in IDLE updates `hi`/`lo` in the next cycle.

## Test plan
- **Signed MULT:** MULT `rs_val` = 0xFFFFFFFD (−3), `rt_val` = 7. Expect `busy` high for exactly 33 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFEB.
- **Unsigned MULTU:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Rerun the same operands as MULT → HI = 0, LO = 1.
- **Signed DIV:** DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5, with `div_by_zero` high for exactly one cycle, coincident with `busy` falling.
- **Stall during busy:** Hold `rd_hi` from cycle T+1 after a MULT. Expect `mult_div_stall` = 1 in T+1 … T+33 and 0 in T+34 with the final HI present. An MTLO held during `busy` leaves LO unchanged until the operation is accepted after `busy` falls.
- **Reset mid-operation:** Drop `rst_n` at cycle T+10 of a DIV. Expect `busy`, `hi`, `lo` and `mult_div_stall` to go to 0 immediately. After release, a fresh MULTU 3 × 4 yields LO = 12 with the full 33-cycle latency.
